// File: rtl/idea_enc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : idea_enc_ctrl_if
// Description : Host stream, sink and external round-unit signals of the
//               iterative IDEA encryption controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface idea_enc_ctrl_if;
  // key load handshake
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  // plaintext handshake
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  // ciphertext handshake
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  // shared combinational round unit
  logic [63:0]  round_in;
  logic [95:0]  round_key;
  logic [63:0]  round_out;
  // status
  logic         busy;

  // controller side
  modport slave (
    input  key_valid, key, in_valid, in_data, out_ready, round_out,
    output key_ready, in_ready, out_valid, out_data, round_in, round_key, busy
  );

  // host / sink / round-unit side
  modport master (
    output key_valid, key, in_valid, in_data, out_ready, round_out,
    input  key_ready, in_ready, out_valid, out_data, round_in, round_key, busy
  );
endinterface
`default_nettype wire

// File: rtl/idea_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : idea_enc_ctrl
// Description : Iterative IDEA encryption controller. Expands a 128-bit key
//               into 52 subkeys, then sequences each 64-bit block through one
//               external combinational round unit for 8 cycles and applies
//               the output transform (10-cycle block latency).
// Revision    : 1.0 - initial release
// ============================================================================
module idea_enc_ctrl #(
  parameter int NROUNDS  = 8,
  parameter int KEXP_CYC = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  idea_enc_ctrl_if.slave bus
);

  localparam logic [2:0] c_RCNT_LAST = 3'(NROUNDS - 1);
  localparam logic [2:0] c_KCNT_LAST = 3'(KEXP_CYC - 1);
  localparam int         c_NSUB      = 52;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_ROUND = 3'd2,
    S_OUTX  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic [127:0] r_key;         // rotating key register
  logic [2:0]   r_kcnt;        // key-expansion pass
  logic [2:0]   r_rcnt;        // round index
  logic         r_key_loaded;
  logic [63:0]  r_st;          // block state between rounds
  logic [63:0]  r_out_data;
  logic         r_out_valid;

  logic [15:0]  w_zk [c_NSUB];
  logic         w_key_acc;
  logic         w_in_rdy;
  logic         w_in_acc;
  logic         w_out_acc;
  logic [5:0]   w_rk_base;
  logic [95:0]  w_rk;
  logic [63:0]  w_outx;

  // Multiplication modulo 2^16+1 where the all-zero word stands for 2^16.
  // A zero operand means -1, so the product is simply 1 - other (mod 2^16).
  // Otherwise the low-high trick: hi*2^16 + lo == lo - hi (mod 2^16+1).
  function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] lo;
    logic [15:0] hi;
    p  = a * b;
    lo = p[15:0];
    hi = p[31:16];
    if (a == 16'd0) begin
      f_mul = 16'd1 - b;
    end else if (b == 16'd0) begin
      f_mul = 16'd1 - a;
    end else begin
      f_mul = lo - hi + {15'd0, (lo < hi)};
    end
  endfunction

  assign w_key_acc = (r_state == S_IDLE) && bus.key_valid;
  assign w_in_rdy  = (r_state == S_IDLE) && r_key_loaded && !bus.key_valid;
  assign w_in_acc  = w_in_rdy && bus.in_valid;
  assign w_out_acc = r_out_valid && bus.out_ready;

  // Subkey file: subkey gi takes word gi%8 of the rotating register during
  // expansion pass gi/8; words past Z52 on the last pass have no home.
  genvar gi;
  generate
    for (gi = 0; gi < c_NSUB; gi++) begin : g_zk
      logic [15:0] r_z;
      // load this subkey on its expansion pass
      always_ff @(posedge clk) begin
        if ((r_state == S_KEXP) && (r_kcnt == 3'(gi / 8))) begin
          r_z <= r_key[127 - 16 * (gi % 8) -: 16];
        end
      end
      assign w_zk[gi] = r_z;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: key has priority over plaintext in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_key_acc) begin
          w_next = S_KEXP;
        end else if (w_in_acc) begin
          w_next = S_ROUND;
        end
      end
      S_KEXP:  if (r_kcnt == c_KCNT_LAST) w_next = S_IDLE;
      S_ROUND: if (r_rcnt == c_RCNT_LAST) w_next = S_OUTX;
      S_OUTX:  w_next = S_HOLD;
      S_HOLD:  if (w_out_acc) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: key rotation, round state, counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= '0;
      r_kcnt       <= '0;
      r_rcnt       <= '0;
      r_key_loaded <= 1'b0;
      r_st         <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_acc) begin
            r_key  <= bus.key;
            r_kcnt <= '0;
          end else if (w_in_acc) begin
            r_st   <= bus.in_data;
            r_rcnt <= '0;
          end
        end
        S_KEXP: begin
          r_key  <= {r_key[102:0], r_key[127:103]};
          r_kcnt <= r_kcnt + 3'd1;
          if (r_kcnt == c_KCNT_LAST) begin
            r_key_loaded <= 1'b1;
          end
        end
        S_ROUND: begin
          r_st   <= bus.round_out;
          r_rcnt <= r_rcnt + 3'd1;
        end
        S_OUTX: begin
          r_out_data  <= w_outx;
          r_out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_out_acc) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Round subkeys Z(6r+1)..Z(6r+6); base index 6*r built from shifts
  assign w_rk_base = {1'b0, r_rcnt, 2'b00} + {2'b00, r_rcnt, 1'b0};

  // Present the current round's subkeys only while a round is in progress
  always_comb begin
    w_rk = '0;
    if (r_state == S_ROUND) begin
      w_rk = {w_zk[w_rk_base],         w_zk[w_rk_base + 6'd1],
              w_zk[w_rk_base + 6'd2],  w_zk[w_rk_base + 6'd3],
              w_zk[w_rk_base + 6'd4],  w_zk[w_rk_base + 6'd5]};
    end
  end

  // Output transform; the middle words are crossed back because every
  // external round swaps them, including the last one
  assign w_outx = {f_mul(r_st[63:48], w_zk[48]),
                   r_st[31:16] + w_zk[49],
                   r_st[47:32] + w_zk[50],
                   f_mul(r_st[15:0],  w_zk[51])};

  assign bus.key_ready = (r_state == S_IDLE);
  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.round_in  = (r_state == S_ROUND) ? r_st : 64'd0;
  assign bus.round_key = w_rk;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
